// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decode-side handshake
// and status outputs. The fetch unit connects through the master modport.
interface instruction_fetch_if;
    // instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // decode-side control
    logic        stall;
    logic        redirect;
    logic        redirect_abs;
    logic [31:0] redirect_imm;

    // fetched instruction and status
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] retired;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  redirect_abs,
        input  redirect_imm,
        output instr,
        output instr_pc,
        output instr_valid,
        output fetch_err,
        output retired
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output stall,
        output redirect,
        output redirect_abs,
        output redirect_imm,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        input  fetch_err,
        input  retired
    );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests a word, holds it for
// decode until consumed, then steps sequentially or follows a redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    instruction_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] instr_pc_reg, instr_pc_next;
    logic        fetch_err_reg, fetch_err_next;
    logic [31:0] retired_reg, retired_next;

    logic        consume;
    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] abs_pc;
    logic [31:0] target_pc;
    logic        target_misaligned;

    // Redirect inputs only matter in the consume cycle; the target is derived
    // from the presented instruction's own address, not the live pc.
    assign consume           = (state_reg == VALID) && !bus.stall;
    assign seq_pc            = instr_pc_reg + 32'd4;
    assign rel_pc            = seq_pc + bus.redirect_imm;
    assign abs_pc            = {bus.redirect_imm[31:1], 1'b0};
    assign target_pc         = !bus.redirect    ? seq_pc :
                               bus.redirect_abs ? abs_pc : rel_pc;
    assign target_misaligned = |target_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            instr_reg     <= 32'd0;
            instr_pc_reg  <= 32'd0;
            fetch_err_reg <= 1'b0;
            retired_reg   <= 32'd0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            instr_reg     <= instr_next;
            instr_pc_reg  <= instr_pc_next;
            fetch_err_reg <= fetch_err_next;
            retired_reg   <= retired_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        instr_next     = instr_reg;
        instr_pc_next  = instr_pc_reg;
        fetch_err_next = fetch_err_reg;
        retired_next   = retired_reg;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_next    = bus.imem_rdata;
                    instr_pc_next = pc_reg;
                    state_next    = VALID;
                end
            end
            VALID: begin
                if (consume) begin
                    retired_next = retired_reg + 32'd1;
                    pc_next      = target_pc;
                    // A misaligned target is fatal until reset.
                    if (target_misaligned) begin
                        fetch_err_next = 1'b1;
                        state_next     = HALT;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request and valid are pure state decodes so they drop in the same
    // cycle the FSM leaves FETCH or VALID.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        case (state_reg)
            FETCH:   bus.imem_req    = 1'b1;
            VALID:   bus.instr_valid = 1'b1;
            default: begin
                bus.imem_req    = 1'b0;
                bus.instr_valid = 1'b0;
            end
        endcase
    end

    assign bus.imem_addr = pc_reg;
    assign bus.instr     = instr_reg;
    assign bus.instr_pc  = instr_pc_reg;
    assign bus.fetch_err = fetch_err_reg;
    assign bus.retired   = retired_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected {instr, pc}
// pairs into a queue, a negedge monitor pops them on every consume.
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;
    logic [31:0] last_instr;
    logic [31:0] last_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consume must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL consume_unexpected: got pc %h expected no consume", bus.instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("instr", bus.instr, mon_e[63:32]);
                check("instr_pc", bus.instr_pc, mon_e[31:0]);
                $display("consume pc=%h instr=%h", bus.instr_pc, bus.instr);
            end
        end
    end

    task automatic check_reset_state;
        check1("rst_req", bus.imem_req, 1'b0);
        check1("rst_valid", bus.instr_valid, 1'b0);
        check("rst_addr", bus.imem_addr, 32'h0000_0000);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check1("rst_err", bus.fetch_err, 1'b0);
        check("rst_retired", bus.retired, 32'h0);
    endtask

    // Wait for a request, check its address, answer after 'delay' cycles.
    task automatic fetch(input logic [31:0] rdata, input int delay);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        check1("req_seen", bus.imem_req, 1'b1);
        check("fetch_addr", bus.imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            step;
            check("addr_hold", bus.imem_addr, exp_pc);
            check1("valid_wait", bus.instr_valid, 1'b0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        exp_q.push_back({rdata, exp_pc});
        last_instr = rdata;
        last_pc    = exp_pc;
        step;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        check1("valid_after_ack", bus.instr_valid, 1'b1);
        check1("req_after_ack", bus.imem_req, 1'b0);
    endtask

    // Hold for 'nstall' cycles with hostile redirect/ack inputs, then consume.
    task automatic consume(input int nstall, input logic red, input logic ab,
                           input logic [31:0] imm, input logic [31:0] exp_next,
                           input logic exp_err);
        for (int i = 0; i < nstall; i++) begin
            bus.stall        = 1'b1;
            bus.redirect     = 1'b1;
            bus.redirect_abs = 1'b1;
            bus.redirect_imm = 32'h0000_0002;
            bus.imem_ack     = 1'b1;
            bus.imem_rdata   = 32'hDEAD_BEEF;
            step;
            check1("stall_valid", bus.instr_valid, 1'b1);
            check("stall_instr", bus.instr, last_instr);
            check("stall_instr_pc", bus.instr_pc, last_pc);
            check("stall_retired", bus.retired, exp_retired);
        end
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.stall        = 1'b0;
        bus.redirect     = red;
        bus.redirect_abs = ab;
        bus.redirect_imm = imm;
        step;
        bus.stall        = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_abs = 1'b0;
        bus.redirect_imm = 32'h0;
        exp_retired++;
        exp_pc = exp_next;
        check("retired", bus.retired, exp_retired);
        check1("fetch_err", bus.fetch_err, exp_err);
        check1("valid_after_consume", bus.instr_valid, 1'b0);
        check1("req_after_consume", bus.imem_req, !exp_err);
        if (!exp_err)
            check("next_addr", bus.imem_addr, exp_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.stall        = 1'b1;
        bus.redirect     = 1'b0;
        bus.redirect_abs = 1'b0;
        bus.redirect_imm = 32'h0;
        exp_pc           = 32'h0;
        exp_retired      = 32'h0;
        last_instr       = 32'h0;
        last_pc          = 32'h0;

        step;
        step;
        check_reset_state();
        rst = 1'b0;
        check1("idle_req", bus.imem_req, 1'b0);

        // first fetch: ack in first FETCH cycle, consume immediately
        fetch(32'h0000_0013, 0);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);

        fetch(32'h0000_0093, 2);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b0);
        fetch(32'h0010_0113, 1);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 1'b0);
        fetch(32'h0020_0193, 0);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 1'b0);

        // three stall cycles with ignored redirect and ack
        fetch(32'h00A0_0213, 0);
        consume(3, 1'b0, 1'b0, 32'h0, 32'h0000_0014, 1'b0);
        fetch(32'h0000_0293, 0);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0018, 1'b0);
        fetch(32'h0000_0313, 0);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_001C, 1'b0);
        fetch(32'h0000_0393, 0);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0020, 1'b0);

        // relative branch back by 8 from 0x20
        fetch(32'hFE00_0CE3, 0);
        consume(1, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0000_0018, 1'b0);

        // absolute jump, bit 0 cleared
        fetch(32'h1000_0067, 0);
        consume(0, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_0100, 1'b0);

        // jump to top of address space, then sequential wrap to 0
        fetch(32'h2000_0067, 0);
        consume(0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        fetch(32'h0000_0413, 0);
        force dut.retired_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retired_reg;
        exp_retired = 32'hFFFF_FFFF;
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b0);

        // misaligned absolute target halts the unit
        fetch(32'h3000_0067, 0);
        consume(0, 1'b1, 1'b1, 32'h0000_0102, 32'h0000_0102, 1'b1);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0BAD_0BAD;
        bus.stall      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check1("halt_req", bus.imem_req, 1'b0);
            check1("halt_valid", bus.instr_valid, 1'b0);
            check1("halt_err", bus.fetch_err, 1'b1);
            check("halt_retired", bus.retired, exp_retired);
        end
        bus.imem_ack = 1'b0;
        bus.stall    = 1'b1;

        // reset out of HALT
        rst = 1'b1;
        step;
        check_reset_state();
        rst         = 1'b0;
        exp_pc      = 32'h0;
        exp_retired = 32'h0;

        fetch(32'h0000_0013, 0);
        consume(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0);

        // reset mid-FETCH at 0x40, then a stray ack in the following IDLE cycle
        check1("fetch40_req", bus.imem_req, 1'b1);
        check("fetch40_addr", bus.imem_addr, 32'h0000_0040);
        rst = 1'b1;
        step;
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0BAD_F00D;
        step;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_pc      = 32'h0;
        exp_retired = 32'h0;
        check1("stray_ack_valid", bus.instr_valid, 1'b0);
        check1("stray_ack_req", bus.imem_req, 1'b1);
        check("stray_ack_addr", bus.imem_addr, 32'h0000_0000);
        check("stray_ack_retired", bus.retired, 32'h0);
        check("stray_ack_instr", bus.instr, 32'h0);
        step;
        check1("still_fetch_valid", bus.instr_valid, 1'b0);

        fetch(32'h0000_0513, 0);
        consume(0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);

        step;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address of the first fetch after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL be the read address, word-aligned.
REQ-006 imem_ack  input  1  SHALL be asserted for one cycle by memory when imem_rdata is valid.
REQ-007 imem_rdata  input  32  SHALL be the instruction word; sampled only in the ack cycle.
REQ-008 stall  input  1  SHALL signal that the consumer cannot accept the presented instruction this cycle.
REQ-009 redirect  input  1  SHALL mark a taken branch or jump for the presented instruction.
REQ-010 redirect_abs  input  1  SHALL select absolute (1) or PC-relative (0) target.
REQ-011 redirect_imm  input  32  SHALL be the immediate-decoder output: relative offset minus 4 when redirect_abs=0, or absolute target when redirect_abs=1.
REQ-012 instr  output  32  SHALL be the fetched instruction presented to decode.
REQ-013 instr_pc  output  32  SHALL be the address of instr.
REQ-014 instr_valid  output  1  SHALL mark instr and instr_pc as valid.
REQ-015 fetch_err  output  1  SHALL be a sticky misaligned-target flag.
REQ-016 retired  output  32  SHALL count consumed instructions.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, VALID and HALT.
REQ-018 In IDLE: imem_req=0, instr_valid=0; next state FETCH with imem_addr=pc.
REQ-019 In FETCH: imem_req=1, imem_addr=pc held stable until ack; on imem_ack, instr<=imem_rdata, instr_pc<=pc, next state VALID.
REQ-020 In VALID: instr_valid=1, imem_req=0; instr and instr_pc SHALL stay stable while stall=1.
REQ-021 Consume event = VALID and stall=0; on it, retired SHALL increment by 1, wrapping modulo 2^32.
REQ-022 On consume with redirect=0, next pc SHALL be instr_pc+4; next state FETCH.
REQ-023 On consume with redirect=1 and redirect_abs=0, next pc SHALL be instr_pc+4+redirect_imm, 32-bit, wrapping modulo 2^32.
REQ-024 On consume with redirect=1 and redirect_abs=1, next pc SHALL be redirect_imm with bit 0 cleared.
REQ-025 If the computed next pc has bits [1:0]!=0, fetch_err SHALL set, and the FSM SHALL enter HALT; otherwise the next state is FETCH.
REQ-026 In HALT: imem_req=0, instr_valid=0; the FSM SHALL remain in HALT until rst.
REQ-027 redirect, redirect_abs and redirect_imm SHALL be ignored in any cycle other than a consume event; a redirect during stall SHALL take effect only in the cycle stall falls.
REQ-028 imem_ack SHALL be ignored in IDLE, VALID and HALT.
REQ-029 Minimum latency SHALL be 1 cycle from request to VALID, when ack arrives in the first FETCH cycle. Back-to-back throughput SHALL be one instruction per 2 cycles.
REQ-030 When ack and consume would coincide, no conflict SHALL arise, because they are exclusive by state.

Reset
REQ-031 While rst=1 at a clock edge: state<=IDLE, pc<=RESET_PC, instr<=0, instr_pc<=0, instr_valid=0, imem_req=0, fetch_err<=0, retired<=0.
REQ-032 Reset SHALL take priority over all other inputs, including a reset asserted mid-FETCH. A pending ack arriving in the following IDLE cycle SHALL be discarded.
REQ-033 imem_addr SHALL equal pc at all times, reading RESET_PC after reset.

Verification
REQ-034 Release rst; ack in 1st FETCH cycle with rdata=32'h0000_0013, stall=0 -> instr_valid at cycle 2, instr_pc=0, next fetch addr=4, retired=1.
REQ-035 VALID at instr_pc=32'h10 with stall=1 for 3 cycles, then stall=0 -> instr stable for 4 cycles, single consume, next addr=32'h14.
REQ-036 Consume at instr_pc=32'h20 with redirect=1, redirect_abs=0, redirect_imm=32'hFFFF_FFF4 (offset -8) -> next addr=32'h18.
REQ-037 Consume with redirect=1, redirect_abs=1, redirect_imm=32'h0000_0101 -> addr bit0 cleared gives 32'h100. With redirect_imm=32'h102 -> fetch_err=1, HALT, imem_req stays 0.
REQ-038 Assert rst during FETCH at pc=32'h40; drive ack in the following IDLE cycle -> ack ignored, next request at RESET_PC, retired=0.
REQ-039 Preload retired=32'hFFFF_FFFF by forcing, then consume -> retired=0; instr_pc=32'hFFFF_FFFC with no redirect -> next addr=0.
